imem_loader: RTL and testbench

Boot-time writer for the core's 32-bit, word-addressed instruction memory. It accepts a byte stream over a valid/ready handshake, framed as a word count, instruction words and a checksum. It assembles little-endian 32-bit words and issues one write strobe per word at ascending word-aligned byte addresses. It holds the core in reset until the image has loaded and the checksum has verified.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_STEP = 4;
  localparam int unsigned COUNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  // States in which the loader accepts a stream byte.
  function automatic logic takes_byte(state_e s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  // master: byte source and memory observer; slave: the loader
  modport master (output in_valid, in_data,
                  input  in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word shifter: new bytes enter at the top, older bytes move down.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic              full_c
);

  logic [1:0] cnt_q;

  // Asserts on the load that completes a word, so the FSM can move to WRITE on that edge.
  assign full_c = load && (cnt_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      word  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      word  <= {din, word[WORD_W-1:BYTE_W]};
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into instruction-memory writes and releases the core on a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             core_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  state_e              state_q, state_d;
  logic                ready_q, we_q;
  logic [WORD_W-1:0]   addr_q;
  logic [BYTE_W-1:0]   xor_q, n_lo_q;
  logic [COUNT_W-1:0]  n_q, n_rx_c;
  logic                xfer, enter_load, asm_full_c;
  logic [WORD_W-1:0]   asm_word;

  assign xfer       = bus.in_valid && ready_q;
  assign n_rx_c     = {bus.in_data, n_lo_q};
  assign enter_load = (state_d == ST_CNT_LO) && (state_q != ST_CNT_LO);

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = asm_word;

  word_assembler u_asm (
    .clk    (clk),
    .reset  (reset),
    .load   (xfer && (state_q == ST_DATA)),
    .clear  (enter_load),
    .din    (bus.in_data),
    .word   (asm_word),
    .full_c (asm_full_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_CNT_LO;
      ST_CNT_LO: if (xfer) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (xfer) begin
          if (n_rx_c > COUNT_W'(DEPTH)) state_d = ST_ERROR;
          else if (n_rx_c == '0)        state_d = ST_CSUM;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA:  if (asm_full_c) state_d = ST_WRITE;
      ST_WRITE: state_d = (COUNT_W'(words_loaded) + COUNT_W'(1) < n_q) ? ST_DATA : ST_CSUM;
      ST_CSUM: begin
        if (xfer) state_d = (bus.in_data == xor_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the deciding edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_hold    <= 1'b1;
      addr_q       <= '0;
      words_loaded <= '0;
      xor_q        <= '0;
      n_lo_q       <= '0;
      n_q          <= '0;
    end else begin
      ready_q   <= takes_byte(state_d);
      we_q      <= (state_d == ST_WRITE);
      done      <= (state_d == ST_DONE);
      error     <= (state_d == ST_ERROR);
      core_hold <= (state_d != ST_DONE);
      if (enter_load) begin
        addr_q       <= '0;
        words_loaded <= '0;
        xor_q        <= '0;
      end else begin
        if (xfer && (state_q != ST_CSUM)) xor_q <= xor_q ^ bus.in_data;
        if (state_q == ST_WRITE) begin
          addr_q       <= addr_q + WORD_W'(ADDR_STEP);
          words_loaded <= words_loaded + CNT_W'(1);
        end
      end
      if (xfer && (state_q == ST_CNT_LO)) n_lo_q <= bus.in_data;
      if (xfer && (state_q == ST_CNT_HI)) n_q    <= n_rx_c;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             core_hold, done, error;
  logic [CNT_W-1:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(32), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture write strobes; the loader must never be ready while writing.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      check("ready_during_write", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      check("stall_is_write", 32'(bus.mem_we), 32'd1);
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum, input bit gap);
    logic [7:0] frame [10];
    frame = '{8'h02, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00};
    for (int i = 0; i < 10; i++) send(frame[i], gap);
    send(csum, gap);
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    check({tag, "_a0"}, (wr_addr.size() > 0) ? wr_addr[0] : 32'hDEAD_BEEF, 32'h0);
    check({tag, "_d0"}, (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD_BEEF, 32'h0000_1137);
    check({tag, "_a1"}, (wr_addr.size() > 1) ? wr_addr[1] : 32'hDEAD_BEEF, 32'h4);
    check({tag, "_d1"}, (wr_data.size() > 1) ? wr_data[1] : 32'hDEAD_BEEF, 32'h0030_0113);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"},  32'(core_hold),     32'd1);
    check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  bus.mem_addr,       32'd0);
    check({tag, "_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, "_done"},  32'(done),          32'd0);
    check({tag, "_error"}, 32'(error),         32'd0);
    check({tag, "_words"}, 32'(words_loaded),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Nominal two-word image
    do_start();
    send_frame(8'h06, 1'b0);
    check_nominal_writes("nom");
    check("nom_done",  32'(done),         32'd1);
    check("nom_hold",  32'(core_hold),    32'd0);
    check("nom_error", 32'(error),        32'd0);
    check("nom_words", 32'(words_loaded), 32'd2);
    check("nom_ready", 32'(bus.in_ready), 32'd0);

    // Bad checksum: writes still land, then error
    do_start();
    send_frame(8'h07, 1'b0);
    check_nominal_writes("bad");
    check("bad_error", 32'(error),        32'd1);
    check("bad_done",  32'(done),         32'd0);
    check("bad_hold",  32'(core_hold),    32'd1);
    check("bad_words", 32'(words_loaded), 32'd2);

    // Count above DEPTH
    do_start();
    send(8'h21, 1'b0);
    send(8'h00, 1'b0);
    check("big_error", 32'(error),          32'd1);
    check("big_ready", 32'(bus.in_ready),   32'd0);
    check("big_hold",  32'(core_hold),      32'd1);
    repeat (3) @(posedge clk); #1;
    check("big_nwr",   32'(wr_addr.size()), 32'd0);

    // Empty image
    do_start();
    check("zero_error_cleared", 32'(error), 32'd0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("zero_done",  32'(done),           32'd1);
    check("zero_hold",  32'(core_hold),      32'd0);
    check("zero_nwr",   32'(wr_addr.size()), 32'd0);
    check("zero_words", 32'(words_loaded),   32'd0);

    // Throttled source
    do_start();
    send_frame(8'h06, 1'b1);
    check_nominal_writes("gap");
    check("gap_done",  32'(done),         32'd1);
    check("gap_hold",  32'(core_hold),    32'd0);
    check("gap_words", 32'(words_loaded), 32'd2);

    // Reset mid-load, then reload from address 0
    do_start();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h37, 1'b0);
    send(8'h11, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid");
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_nwr", 32'(wr_addr.size()), 32'd0);
    do_start();
    send_frame(8'h06, 1'b0);
    check_nominal_writes("rel");
    check("rel_done", 32'(done),      32'd1);
    check("rel_hold", 32'(core_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
